// File: rtl/gsm_pkg.sv
// Shared definitions for the game-state-manager command path: command flag
// encodings and the arbiter FSM states.
package gsm_pkg;

    localparam logic [3:0] FLAG_SCORE_INC  = 4'b0001;
    localparam logic [3:0] FLAG_LIFE_DEC   = 4'b0010;
    localparam logic [3:0] FLAG_PAUSE      = 4'b0100;
    localparam logic [3:0] FLAG_RESUME     = 4'b0101;
    localparam logic [3:0] FLAG_TO_READY   = 4'b1000;
    localparam logic [3:0] FLAG_TO_PLAY    = 4'b1010;
    localparam logic [3:0] FLAG_STAGE_CLR  = 4'b1100;
    localparam logic [3:0] FLAG_GAME_OVER  = 4'b1101;
    localparam logic [3:0] FLAG_GAME_CLR   = 4'b1110;
    localparam logic [3:0] FLAG_FULL_RESET = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_TRIG    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/gsm_cmd_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of mask at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/gsm_cmd_arbiter.sv
// Serialises requester commands onto the manager's flag/trig/done port.
// State-transition commands beat counter commands; round-robin within a class.
module gsm_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DONE_TIMEOUT = 16,
    parameter int LOW_CYCLES   = 3,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk_1mhz,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_flag,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [3:0]             flag,
    output logic                   trig,
    input  logic                   done,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [7:0]             timeout_cnt
);
    import gsm_pkg::*;

    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam int LW = $clog2(LOW_CYCLES + 1);

    arb_state_e         state_q, state_d;
    logic [3:0]         flag_q, flag_d;
    logic               trig_q, trig_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [LW-1:0]      lcnt_q, lcnt_d;
    logic [7:0]         tocnt_q, tocnt_d;

    logic [NUM_REQ-1:0] hi_mask, lo_mask;
    logic [IDX_W-1:0]   hi_idx, lo_idx, pick_idx, rr_next;
    logic               hi_found, lo_found;

    always_comb begin
        hi_mask = '0;
        lo_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = req_valid[i] &  req_flag[4*i+3];
            lo_mask[i] = req_valid[i] & ~req_flag[4*i+3];
        end
    end

    rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick_hi (
        .mask(hi_mask), .ptr(rr_ptr_q), .idx(hi_idx), .found(hi_found)
    );
    rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick_lo (
        .mask(lo_mask), .ptr(rr_ptr_q), .idx(lo_idx), .found(lo_found)
    );

    assign pick_idx = hi_found ? hi_idx : lo_idx;
    assign rr_next  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        trig_d   = trig_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = '0;
        err_d    = '0;
        tcnt_d   = tcnt_q;
        lcnt_d   = lcnt_q;
        tocnt_d  = tocnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hi_found || lo_found) begin
                    grant_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (IDX_W'(i) == pick_idx) flag_d = req_flag[4*i +: 4];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                trig_d  = 1'b1;
                tcnt_d  = '0;
                state_d = ST_TRIG;
            end
            ST_TRIG: begin
                // done takes precedence over a timeout landing in the same cycle
                if (done || tcnt_q == TW'(DONE_TIMEOUT - 1)) begin
                    trig_d         = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    rr_ptr_d       = rr_next;
                    lcnt_d         = '0;
                    state_d        = ST_RELEASE;
                    if (!done) begin
                        err_d[grant_q] = 1'b1;
                        if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (lcnt_q == LW'(LOW_CYCLES - 1)) state_d = ST_IDLE;
                else                               lcnt_d  = lcnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            flag_q   <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            tcnt_q   <= '0;
            lcnt_q   <= '0;
            tocnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
            lcnt_q   <= lcnt_d;
            tocnt_q  <= tocnt_d;
        end
    end

    assign req_ack     = ack_q;
    assign req_err     = err_q;
    assign flag        = flag_q;
    assign trig        = trig_q;
    assign busy        = busy_q;
    assign grant_idx   = grant_q;
    assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_gsm_cmd_arbiter.sv
// Bench for gsm_cmd_arbiter: single-command vector table, hand-written
// multi-cycle sequences, and a randomized run against a timeline model.
module tb_gsm_cmd_arbiter;
    import gsm_pkg::*;

    localparam int LOWC = 3;
    localparam int TOUT = 16;

    logic        clk_1mhz = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_flag;
    logic [3:0]  req_ack, req_err, flag;
    logic        trig, done, busy;
    logic [1:0]  grant_idx;
    logic [7:0]  timeout_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int got[$];

    gsm_cmd_arbiter #(.NUM_REQ(4), .DONE_TIMEOUT(TOUT), .LOW_CYCLES(LOWC)) dut (
        .clk_1mhz(clk_1mhz), .rst(rst), .req_valid(req_valid), .req_flag(req_flag),
        .req_ack(req_ack), .req_err(req_err), .flag(flag), .trig(trig), .done(done),
        .busy(busy), .grant_idx(grant_idx), .timeout_cnt(timeout_cnt)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] flags;
        int          lat;
        int          exp_idx;
        logic [3:0]  exp_flag;
        int          exp_h;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] flist[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_flag  = '0;
        done      = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk_1mhz);
        @(negedge clk_1mhz);
        rst = 1'b0;
    endtask

    task automatic wait_trig(input string nm);
        int c = 0;
        while (!trig && c < 20) begin
            @(posedge clk_1mhz); #1;
            c++;
        end
        chk(nm, trig, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  hc;
        bit  got_ack, trig_bad;
        int  lc;
        logic [3:0] a, e;
        do_reset();
        req_flag  = v.flags;
        req_valid = v.valid;
        @(posedge clk_1mhz); #1;
        chk($sformatf("v%0d_setup_busy", id), busy, 1);
        chk($sformatf("v%0d_setup_trig", id), trig, 0);
        chk($sformatf("v%0d_flag", id), flag, v.exp_flag);
        chk($sformatf("v%0d_grant", id), grant_idx, v.exp_idx);
        @(posedge clk_1mhz); #1;
        chk($sformatf("v%0d_trig_rise", id), trig, 1);
        hc = 1; got_ack = 0; a = '0; e = '0;
        for (int k = 1; k <= 40 && !got_ack; k++) begin
            @(negedge clk_1mhz);
            done = (k == v.lat);
            @(posedge clk_1mhz); #1;
            if (req_ack != 0) begin
                got_ack = 1; a = req_ack; e = req_err;
                chk($sformatf("v%0d_trig_fall", id), trig, 0);
            end else if (trig) hc++;
        end
        @(negedge clk_1mhz);
        done = 1'b0;
        req_valid = '0;
        chk($sformatf("v%0d_ack_seen", id), got_ack, 1);
        chk($sformatf("v%0d_ack", id), a, 4'b0001 << v.exp_idx);
        chk($sformatf("v%0d_err", id), e, v.exp_err ? (4'b0001 << v.exp_idx) : 4'b0000);
        chk($sformatf("v%0d_trig_high", id), hc, v.exp_h);
        chk($sformatf("v%0d_tocnt", id), timeout_cnt, v.exp_err ? 1 : 0);
        // ack was sampled one posedge ago; count the further posedges busy stays up
        lc = 1; trig_bad = 0;
        while (busy && lc < 20) begin
            @(posedge clk_1mhz); #1;
            if (trig) trig_bad = 1;
            if (busy) lc++;
            @(negedge clk_1mhz);
        end
        chk($sformatf("v%0d_low_cycles", id), lc, LOWC);
        chk($sformatf("v%0d_trig_low", id), trig_bad, 0);
    endtask

    // Auto-responds done one cycle after trig and collects ack indices.
    task automatic serve(input logic [3:0] v, input logic [15:0] f, input bit hold, input int nacks);
        int clr = -1;
        got.delete();
        req_flag  = f;
        req_valid = v;
        for (int c = 0; c < 200 && got.size() < nacks; c++) begin
            @(negedge clk_1mhz);
            done = trig;
            if (clr >= 0 && !hold) req_valid[clr] = 1'b0;
            clr = -1;
            @(posedge clk_1mhz); #1;
            for (int i = 0; i < 4; i++)
                if (req_ack[i]) begin got.push_back(i); clr = i; end
        end
        @(negedge clk_1mhz);
        done = 1'b0;
        if (clr >= 0 && !hold) req_valid[clr] = 1'b0;
        chk("serve_ack_count", got.size(), nacks);
    endtask

    function automatic int model_pick(input logic [3:0] v, input logic [15:0] f, input int rr);
        logic [3:0] hi, lo, m;
        for (int i = 0; i < 4; i++) begin
            hi[i] = v[i] &  f[4*i+3];
            lo[i] = v[i] & ~f[4*i+3];
        end
        m = (hi != 0) ? hi : lo;
        for (int k = 0; k < 4; k++)
            if (m[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[5];
        int cnt;
        logic [3:0] a;
        // random-phase model state
        bit m_act;
        int m_rr, m_t0, m_g, m_lat, m_h, m_e, m_done_at, m_clr, m_tocnt, p;
        bit m_to;
        logic [3:0] m_flag, e_ack, e_err;
        logic [1:0] m_grant;
        bit e_busy, e_trig;

        flist = '{FLAG_SCORE_INC, FLAG_LIFE_DEC, FLAG_PAUSE, FLAG_RESUME, FLAG_TO_READY,
                  FLAG_TO_PLAY, FLAG_STAGE_CLR, FLAG_GAME_OVER, FLAG_GAME_CLR, FLAG_FULL_RESET};
        vecs[0] = '{4'b0001, 16'h0001, 3,  0, 4'h1, 3,  1'b0};
        vecs[1] = '{4'b0101, 16'h0D01, 2,  2, 4'hD, 2,  1'b0};
        vecs[2] = '{4'b1111, 16'h1111, 1,  0, 4'h1, 1,  1'b0};
        vecs[3] = '{4'b1010, 16'h8020, 5,  3, 4'h8, 5,  1'b0};
        vecs[4] = '{4'b0010, 16'h0040, 20, 1, 4'h4, 16, 1'b1};
        vecs[5] = '{4'b1000, 16'hF000, 16, 3, 4'hF, 16, 1'b0};
        vecs[6] = '{4'b0110, 16'h0EA0, 4,  1, 4'hA, 4,  1'b0};
        vecs[7] = '{4'b1100, 16'hC500, 2,  3, 4'hC, 2,  1'b0};

        // reset state
        rst = 1'b1; req_valid = '0; req_flag = '0; done = 1'b0;
        #1;
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", flag, 0);
        chk("rst_ack", {req_ack, req_err}, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_tocnt", timeout_cnt, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // priority: high class first, then the counter command
        do_reset();
        serve(4'b0101, 16'h0D01, 1'b0, 2);
        chk("prio_first", got.size() > 0 ? got[0] : -1, 2);
        chk("prio_second", got.size() > 1 ? got[1] : -1, 0);

        // round-robin with all requests held
        do_reset();
        exp_rr = '{0, 1, 2, 3, 0};
        serve(4'b1111, 16'h1111, 1'b1, 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), got.size() > k ? got[k] : -1, exp_rr[k]);

        // async reset during TRIG, then pointer restarts at 0
        do_reset();
        serve(4'b0001, 16'h0001, 1'b0, 1);
        cnt = 0;
        while (busy && cnt < 20) begin @(posedge clk_1mhz); #1; cnt++; end
        @(negedge clk_1mhz);
        req_flag = 16'h0011; req_valid = 4'b0011;
        wait_trig("rstmid_trig_up");
        chk("rstmid_grant_before", grant_idx, 1);
        #3 rst = 1'b1;
        #1;
        chk("rstmid_trig_drop", trig, 0);
        chk("rstmid_no_ack", req_ack, 0);
        chk("rstmid_busy", busy, 0);
        @(posedge clk_1mhz);
        @(negedge clk_1mhz);
        rst = 1'b0;
        wait_trig("rstmid_trig_again");
        chk("rstmid_regrant", grant_idx, 0);
        cnt = 0; a = '0;
        while (a == 0 && cnt < 20) begin
            @(negedge clk_1mhz); done = trig;
            @(posedge clk_1mhz); #1; a = req_ack; cnt++;
        end
        chk("rstmid_ack", a, 4'b0001);
        @(negedge clk_1mhz); done = 1'b0;

        // spurious done in IDLE, then a request dropped after grant
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_1mhz); done = 1'b1;
            @(posedge clk_1mhz); #1;
            chk("spur_no_ack", req_ack, 0);
            chk("spur_idle", busy, 0);
        end
        @(negedge clk_1mhz);
        done = 1'b0;
        req_flag[11:8] = FLAG_LIFE_DEC; req_valid = 4'b0100;
        @(posedge clk_1mhz); #1;
        chk("drop_granted", busy, 1);
        @(negedge clk_1mhz); req_valid = '0;
        cnt = 0; a = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_1mhz); done = trig;
            @(posedge clk_1mhz); #1;
            if (req_ack != 0) begin cnt++; a = req_ack; end
        end
        @(negedge clk_1mhz); done = 1'b0;
        chk("drop_ack_once", cnt, 1);
        chk("drop_ack_who", a, 4'b0100);

        // randomized traffic against a command-timeline model
        do_reset();
        m_act = 0; m_rr = 0; m_flag = '0; m_grant = '0; m_tocnt = 0; m_clr = -1;
        m_done_at = -100; m_t0 = 0; m_g = 0; m_e = 0; m_to = 0; m_lat = 0; m_h = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk_1mhz);
            done = (n == m_done_at);
            if (!m_act && $urandom_range(7) == 0) done = 1'b1;
            if (m_clr >= 0) begin req_valid[m_clr] = 1'b0; m_clr = -1; end
            if (m_act && n == m_t0 + 1 && $urandom_range(3) == 0) req_valid[m_g] = 1'b0;
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] && !(m_act && m_g == i) && $urandom_range(3) == 0) begin
                    req_flag[4*i +: 4] = flist[$urandom_range(9)];
                    req_valid[i] = 1'b1;
                end
            if (!m_act) begin
                p = model_pick(req_valid, req_flag, m_rr);
                if (p >= 0) begin
                    m_act = 1; m_t0 = n; m_g = p;
                    m_flag = req_flag[4*p +: 4]; m_grant = 2'(p);
                    m_lat = $urandom_range(20, 1);
                    m_done_at = n + 1 + m_lat;
                    m_to = (m_lat > TOUT);
                    m_h = m_to ? TOUT : m_lat;
                    m_e = n + 1 + m_h;
                end
            end
            e_ack = '0; e_err = '0; e_busy = 0; e_trig = 0;
            if (m_act) begin
                e_busy = (n <= m_e + LOWC - 1);
                e_trig = (n >= m_t0 + 1) && (n <= m_e - 1);
                if (n == m_e) begin
                    e_ack = 4'b0001 << m_g;
                    if (m_to) begin
                        e_err = e_ack;
                        if (m_tocnt < 255) m_tocnt++;
                    end
                    m_rr = (m_g + 1) % 4;
                    m_clr = m_g;
                end
                if (n == m_e + LOWC) m_act = 0;
            end
            @(posedge clk_1mhz); #1;
            chk("rnd_trig", trig, e_trig);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_ack", req_ack, e_ack);
            chk("rnd_err", req_err, e_err);
            chk("rnd_flag", flag, m_flag);
            chk("rnd_grant", grant_idx, m_grant);
            chk("rnd_tocnt", timeout_cnt, m_tocnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
